message_scheduler: RTL and testbench
====================================

# message_scheduler

Produces the SHA-256 message schedule W[0..63] for one 512-bit block. Words W[0..15] are accepted as a 32-bit stream and passed through; W[16..63] are expanded from a 16-word sliding window using the sigma0/sigma1 functions. It sits between the block padder (upstream) and the compression round engine (downstream), with ready/valid handshakes on both sides.

## Interface
- ROUNDS, 64, number of schedule words emitted per block; legal range 17..64.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a block; honoured only in IDLE
- in_word  in  32  message word from the padder, big-endian order W0 first
- in_valid  in  1  in_word is valid
- in_ready  out  1  scheduler accepts in_word this cycle
- out_word  out  32  schedule word W[t]
- out_index  out  6  t of the word on out_word
- out_valid  out  1  out_word/out_index are valid
- out_ready  in  1  round engine consumes out_word this cycle
- busy  out  1  high in LOAD and EXPAND
- done  out  1  one-cycle pulse after W[ROUNDS-1] is consumed
- abort  in  1  present only with SCHED_ABORT_EN (see Configuration)

## Operation
- States: IDLE, LOAD, EXPAND, DONE. Reset -> IDLE.
- IDLE: start=1 -> LOAD; counter t cleared to 0.
- Output register "free" = !out_valid || out_ready.
- LOAD: in_ready = free (combinational). On in_valid && in_ready: window shifts (w[0]<=w[1] … w[15]<=in_word), out_word<=in_word, out_index<=t, out_valid<=1, t++. After accepting t=15 -> EXPAND.
- EXPAND: when free: new = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], mod 2^32; window shifts in new; out_word<=new, out_index<=t, out_valid<=1, t++. After emitting t=ROUNDS-1, stop generating; move to DONE when that word's out_valid && out_ready.
- DONE: done=1 for exactly one cycle, then IDLE.
- Out_valid drops when the register is consumed and no new word is loaded that cycle.
- sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10. Bitwise XOR, true rotations, computed combinationally inside this block.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0).
- out_word/out_index hold stable while out_valid && !out_ready.

## Timing
- Reset values: state IDLE, t=0, window all 0, out_word=0, out_index=0, out_valid=0, in_ready=0, busy=0, done=0.
- start at cycle 0 -> busy=1 and in_ready=1 at cycle 1.
- Word accepted at cycle n appears on out_word at cycle n+1 (1-cycle latency).
- With in_valid and out_ready held high: one word per cycle, W15 out at cycle 17, W63 out at cycle 65, done at cycle 66, IDLE at cycle 67.
- LOAD to EXPAND transition costs no bubble: W16 follows W15 on the next cycle if out_ready.
- Backpressure: out_ready=0 freezes t, window and outputs; in_ready=0 in LOAD.
- Reset asserted mid-block: immediate return to reset values; partial block discarded.

## Configuration
- SCHED_ABORT_EN defined: adds input abort. abort=1 in any state returns to IDLE on the next edge with out_valid=0, t=0, no done pulse; abort has priority over start and all handshakes. Window contents not cleared.
- Not defined: no abort port; a block always runs to DONE unless reset.

## Test plan
- "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6, W63=0x12B1EDEB, done at cycle 66.
- Random out_ready (50%) and in_valid gaps on the "abc" block -> identical 64-word sequence, out_index 0..63 with no gaps or repeats, out_word stable while stalled.
- start pulsed during EXPAND and in_valid=1 with in_ready=0 -> ignored; sequence unchanged, no extra words consumed.
- reset deasserted/asserted at t=30 -> all outputs 0 next cycle; fresh start then "abc" -> correct W0..W63.
- ROUNDS=20 -> exactly W0..W19 emitted, done after W19 consumed.
- SCHED_ABORT_EN: abort at t=40 -> out_valid=0 next cycle, no done; subsequent start produces correct full sequence.

Source files
------------

// File: rtl/message_scheduler.sv
// message_scheduler: SHA-256 message schedule generator, W[0..ROUNDS-1].
// Passes W0..W15 from the padder, then expands the rest from a 16-word window.
//
// Ports:
//   clock, reset (async, active-low)
//   start              begin a block (honoured in IDLE only)
//   in_word/in_valid/in_ready     message words from the padder
//   out_word/out_index/out_valid/out_ready  schedule words to the round engine
//   busy               high while loading or expanding
//   done               one-cycle pulse after the last word is consumed
//   abort              only when SCHED_ABORT_EN is defined: return to IDLE
//
// Optional feature macro: SCHED_ABORT_EN (adds the abort input).
module message_scheduler #(
    parameter int ROUNDS = 64
) (
    input  logic        clock,
    input  logic        reset,
`ifdef SCHED_ABORT_EN
    input  logic        abort,
`endif
    input  logic        start,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_index,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } state_t;

    localparam logic [6:0] LAST = 7'(ROUNDS);

    state_t      state;
    logic [6:0]  t;
    logic [31:0] w [16];
    logic [31:0] w_new;
    logic        free;
    logic        abort_i;
    logic        accept;

`ifdef SCHED_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Window w[0] is the oldest word (W[t-16]), w[15] the newest (W[t-1]).
    assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

    // The output register can take a new word when empty or being drained.
    assign free     = !out_valid || out_ready;
    assign in_ready = (state == LOAD) && free && !abort_i;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == LOAD) || (state == EXPAND);
    assign done     = (state == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            t         <= '0;
            out_word  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else if (abort_i) begin
            state     <= IDLE;
            t         <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        t     <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        for (int i = 0; i < 15; i++) begin
                            w[i] <= w[i+1];
                        end
                        w[15]     <= in_word;
                        out_word  <= in_word;
                        out_index <= t[5:0];
                        out_valid <= 1'b1;
                        t         <= t + 7'd1;
                        if (t == 7'd15) begin
                            state <= EXPAND;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (t < LAST) begin
                        if (free) begin
                            for (int i = 0; i < 15; i++) begin
                                w[i] <= w[i+1];
                            end
                            w[15]     <= w_new;
                            out_word  <= w_new;
                            out_index <= t[5:0];
                            out_valid <= 1'b1;
                            t         <= t + 7'd1;
                        end
                    end else if (out_ready) begin
                        // Last word is being consumed this cycle.
                        out_valid <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_message_scheduler.sv
// tb_message_scheduler: scoreboard bench for message_scheduler.
// Runs a 64-round and a 20-round instance side by side on one stimulus.
module tb_message_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_word = '0;
`ifdef SCHED_ABORT_EN
    logic        abort = 1'b0;
`endif

    logic        a_ready, a_valid, a_busy, a_done;
    logic        b_ready, b_valid, b_busy, b_done;
    logic [31:0] a_word, b_word;
    logic [5:0]  a_idx, b_idx;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] blk [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_a [64];
    logic [37:0] qa [$];
    logic [37:0] qb [$];
    logic [37:0] ea, eb;

    bit          stall_a, stall_b;
    logic [31:0] hw_a, hw_b;
    logic [5:0]  hi_a, hi_b;
    int pops_a = 0, pops_b = 0, done_a = 0, done_b = 0;
    int dcyc_a = 0, dcyc_b = 0, c15 = 0, clast_a = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    message_scheduler #(.ROUNDS(64)) u_a (
        .clock     (clock),
        .reset     (reset),
`ifdef SCHED_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (a_ready),
        .out_word  (a_word),
        .out_index (a_idx),
        .out_valid (a_valid),
        .out_ready (out_ready),
        .busy      (a_busy),
        .done      (a_done)
    );

    message_scheduler #(.ROUNDS(20)) u_b (
        .clock     (clock),
        .reset     (reset),
`ifdef SCHED_ABORT_EN
        .abort     (abort),
`endif
        .start     (start_b),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (b_ready),
        .out_word  (b_word),
        .out_index (b_idx),
        .out_valid (b_valid),
        .out_ready (out_ready),
        .busy      (b_busy),
        .done      (b_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic fill_ref();
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    // Monitor for the 64-round instance.
    always begin
        @(negedge clock);
        #2;
        if (stall_a && a_valid) begin
            check("a_hold_word", a_word, hw_a);
            check("a_hold_idx", 32'(a_idx), 32'(hi_a));
        end
        stall_a = a_valid && !out_ready;
        hw_a = a_word;
        hi_a = a_idx;
        if (a_valid && out_ready) begin
            if (qa.size() == 0) begin
                check("a_extra_word", 32'(a_idx), 32'hFFFF_FFFF);
            end else begin
                ea = qa.pop_front();
                check("a_idx", 32'(a_idx), 32'(ea[37:32]));
                check("a_word", a_word, ea[31:0]);
                got_a[a_idx] = a_word;
                pops_a++;
                if (a_idx == 6'd15) c15 = cyc;
                if (a_idx == 6'd63) clast_a = cyc;
            end
        end
        if (a_done) begin
            done_a++;
            dcyc_a = cyc;
        end
    end

    // Monitor for the 20-round instance.
    always begin
        @(negedge clock);
        #2;
        if (stall_b && b_valid) begin
            check("b_hold_word", b_word, hw_b);
            check("b_hold_idx", 32'(b_idx), 32'(hi_b));
        end
        stall_b = b_valid && !out_ready;
        hw_b = b_word;
        hi_b = b_idx;
        if (b_valid && out_ready) begin
            if (qb.size() == 0) begin
                check("b_extra_word", 32'(b_idx), 32'hFFFF_FFFF);
            end else begin
                eb = qb.pop_front();
                check("b_idx", 32'(b_idx), 32'(eb[37:32]));
                check("b_word", b_word, eb[31:0]);
                pops_b++;
            end
        end
        if (b_done) begin
            done_b++;
            dcyc_b = cyc;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_word"}, a_word, 32'h0);
        check({tag, "_idx"}, 32'(a_idx), 32'h0);
        check({tag, "_valid"}, 32'(a_valid), 32'h0);
        check({tag, "_in_ready"}, 32'(a_ready), 32'h0);
        check({tag, "_busy"}, 32'(a_busy), 32'h0);
        check({tag, "_done"}, 32'(a_done), 32'h0);
        check({tag, "_b_valid"}, 32'(b_valid), 32'h0);
    endtask

    // cut < 0: run to completion; otherwise stop when W[cut] is shown,
    // by reset (use_abort=0) or by abort (use_abort=1).
    task automatic run_block(input bit rnd, input bit noise, input int cut,
                             input bit use_abort);
        int n, guard, extra, d0a, d0b, p0a, p0b, sc;
        n = 0; guard = 0; extra = 0;
        d0a = done_a; d0b = done_b; p0a = pops_a; p0b = pops_b;
        fill_ref();
        @(negedge clock);
        start = 1'b1; start_b = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        sc = cyc;
        @(negedge clock);
        start = 1'b0; start_b = 1'b0;
        check("busy_after_start", 32'(a_busy), 32'h1);
        check("in_ready_after_start", 32'(a_ready), 32'h1);
        while (guard < 3000) begin
            if (done_a != d0a) break;
            if (cut >= 0 && a_valid && a_idx == 6'(cut)) begin
                out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
                if (use_abort) begin
`ifdef SCHED_ABORT_EN
                    abort = 1'b1;
                    @(negedge clock);
                    abort = 1'b0;
                    check("abort_valid", 32'(a_valid), 32'h0);
                    check("abort_busy", 32'(a_busy), 32'h0);
                    check("abort_done", 32'(a_done), 32'h0);
`endif
                end else begin
                    reset = 1'b0;
                    #1;
                    check_zero("rst_now");
                    @(negedge clock);
                    check_zero("rst_next");
                    reset = 1'b1;
                end
                qa.delete();
                qb.delete();
                repeat (3) @(negedge clock);
                check("cut_no_done", 32'(done_a - d0a), 32'h0);
                return;
            end
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (n < 16) begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_word = in_valid ? blk[n] : $urandom;
            end else begin
                in_valid = noise;
                in_word = $urandom;
            end
            start = noise && (n == 16) && ($urandom_range(0, 3) == 0);
            #1;
            if (in_valid && a_ready) begin
                if (n < 16) begin
                    qa.push_back({6'(n), blk[n]});
                    qb.push_back({6'(n), blk[n]});
                    n++;
                    if (n == 16) begin
                        for (int k = 16; k < 64; k++) qa.push_back({6'(k), exp_w[k]});
                        for (int k = 16; k < 20; k++) qb.push_back({6'(k), exp_w[k]});
                    end
                end else begin
                    extra++;
                end
            end
            @(negedge clock);
            guard++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (guard >= 3000) check("timeout", 32'h1, 32'h0);
        check("a_done_once", 32'(done_a - d0a), 32'h1);
        check("b_done_once", 32'(done_b - d0b), 32'h1);
        check("a_count", 32'(pops_a - p0a), 32'd64);
        check("b_count", 32'(pops_b - p0b), 32'd20);
        check("a_queue_empty", 32'(qa.size()), 32'h0);
        check("b_queue_empty", 32'(qb.size()), 32'h0);
        check("idle_busy", 32'(a_busy), 32'h0);
        check("idle_done", 32'(a_done), 32'h0);
        check("no_extra_accept", 32'(extra), 32'h0);
        if (!rnd) begin
            check("w15_cycle", 32'(c15 - sc), 32'd17);
            check("w63_cycle", 32'(clast_a - sc), 32'd65);
            check("done_cycle", 32'(dcyc_a - sc), 32'd66);
            check("b_done_cycle", 32'(dcyc_b - sc), 32'd22);
        end
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0] = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
    endtask

    initial begin
        load_abc();
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        run_block(1'b0, 1'b0, -1, 1'b0);
        check("abc_w16", got_a[16], 32'h6162_6380);
        check("abc_w17", got_a[17], 32'h000F_0000);
        check("abc_w18", got_a[18], 32'h7DA8_6405);
        check("abc_w19", got_a[19], 32'h6000_03C6);
        check("abc_w63", got_a[63], 32'h12B1_EDEB);

        run_block(1'b1, 1'b1, -1, 1'b0);
        check("rnd_w63", got_a[63], 32'h12B1_EDEB);

        run_block(1'b0, 1'b0, 30, 1'b0);
        run_block(1'b0, 1'b0, -1, 1'b0);
        check("post_rst_w63", got_a[63], 32'h12B1_EDEB);

`ifdef SCHED_ABORT_EN
        run_block(1'b0, 1'b0, 40, 1'b1);
        run_block(1'b0, 1'b0, -1, 1'b0);
        check("post_abort_w63", got_a[63], 32'h12B1_EDEB);
`endif

        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        run_block(1'b1, 1'b0, -1, 1'b0);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
